// File: rtl/mm_tile_sched.sv
// Tiled matmul read/accumulate scheduler: walks m/n/k tiles, issues buffer reads, replays them as accumulator writes.
// Optional performance counters enabled by defining MM_TILE_SCHED_PERF_EN.
`default_nettype none

module mm_tile_sched #(
  parameter int M_TILES  = 8,
  parameter int N_TILES  = 16,
  parameter int PIPE_LAT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_mode,
  input  logic        i_start,
  input  logic        i_stall,
  output logic        o_rd_en,
  output logic [6:0]  o_a_addr,
  output logic [10:0] o_b_addr,
  output logic        o_acc_we,
  output logic [3:0]  o_acc_addr,
  output logic        o_acc_clr,
  output logic        o_acc_last,
  output logic        o_busy,
  output logic        o_done
`ifdef MM_TILE_SCHED_PERF_EN
  ,
  output logic [31:0] o_cycle_cnt,
  output logic [31:0] o_stall_cnt
`endif
);

  localparam int MW = (M_TILES > 1) ? $clog2(M_TILES) : 1;
  localparam int NW = (N_TILES > 1) ? $clog2(N_TILES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      mode_q;
  logic [MW-1:0]   m_cnt;
  logic [NW-1:0]   n_cnt;
  logic [3:0]      k_cnt;
  logic [3:0]      drain_cnt;
  logic [3:0]      k_max;
  logic            issue;
  logic            k_end, n_end, m_end, last_issue;
  logic            start_run;
  logic [MW+3:0]   a_full;
  logic [NW+3:0]   b_full;

  logic [PIPE_LAT-1:0]       pv;
  logic [PIPE_LAT-1:0][3:0]  pslot;
  logic [PIPE_LAT-1:0]       pclr;
  logic [PIPE_LAT-1:0]       plast;

  // Both INT4 flavours pack two values per byte, halving the K depth.
  assign k_max      = (mode_q == 2'd1 || mode_q == 2'd2) ? 4'd7 : 4'd15;
  assign k_end      = (k_cnt == k_max);
  assign n_end      = (n_cnt == NW'(N_TILES - 1));
  assign m_end      = (m_cnt == MW'(M_TILES - 1));
  assign issue      = (state == RUN) && !i_stall;
  assign last_issue = issue && k_end && n_end && m_end;
  assign start_run  = (state == IDLE) && i_start;
  assign a_full     = {m_cnt, k_cnt};
  assign b_full     = {n_cnt, k_cnt};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    o_rd_en   = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) state_nxt = RUN;
      end
      RUN: begin
        o_busy  = 1'b1;
        o_rd_en = issue;
        if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        o_busy = 1'b1;
        if (drain_cnt == 4'(PIPE_LAT - 1)) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q    <= 2'd0;
      m_cnt     <= '0;
      n_cnt     <= '0;
      k_cnt     <= '0;
      drain_cnt <= '0;
    end else begin
      if (start_run) begin
        mode_q <= i_mode;
        m_cnt  <= '0;
        n_cnt  <= '0;
        k_cnt  <= '0;
      end else if (issue) begin
        if (k_end) begin
          k_cnt <= '0;
          if (n_end) begin
            n_cnt <= '0;
            m_cnt <= m_cnt + 1'b1;
          end else begin
            n_cnt <= n_cnt + 1'b1;
          end
        end else begin
          k_cnt <= k_cnt + 1'b1;
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : 4'd0;
    end
  end

  // Fixed-latency replay of every issued read; stall only gates new issues.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pv    <= '0;
      pslot <= '0;
      pclr  <= '0;
      plast <= '0;
    end else begin
      pv[0]    <= issue;
      pslot[0] <= 4'(n_cnt);
      pclr[0]  <= (k_cnt == 4'd0);
      plast[0] <= k_end;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pv[i]    <= pv[i-1];
        pslot[i] <= pslot[i-1];
        pclr[i]  <= pclr[i-1];
        plast[i] <= plast[i-1];
      end
    end
  end

  assign o_a_addr   = o_rd_en ? 7'(a_full) : 7'd0;
  assign o_b_addr   = o_rd_en ? 11'(b_full) : 11'd0;
  assign o_acc_we   = pv[PIPE_LAT-1];
  assign o_acc_addr = o_acc_we ? pslot[PIPE_LAT-1] : 4'd0;
  assign o_acc_clr  = o_acc_we && pclr[PIPE_LAT-1];
  assign o_acc_last = o_acc_we && plast[PIPE_LAT-1];

`ifdef MM_TILE_SCHED_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cycle_cnt <= '0;
      o_stall_cnt <= '0;
    end else if (start_run) begin
      o_cycle_cnt <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (o_busy && o_cycle_cnt != 32'hFFFF_FFFF)
        o_cycle_cnt <= o_cycle_cnt + 32'd1;
      if (state == RUN && i_stall && o_stall_cnt != 32'hFFFF_FFFF)
        o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mm_tile_sched.sv
// Bench for mm_tile_sched: vector table of runs checked cycle by cycle against a loop-nest reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_mm_tile_sched;
  localparam int M_TILES  = 8;
  localparam int N_TILES  = 16;
  localparam int PIPE_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        rd_en, acc_we, acc_clr, acc_last, busy, done;
  logic [6:0]  a_addr;
  logic [10:0] b_addr;
  logic [3:0]  acc_addr;
`ifdef MM_TILE_SCHED_PERF_EN
  logic [31:0] cycle_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  mm_tile_sched #(.M_TILES(M_TILES), .N_TILES(N_TILES), .PIPE_LAT(PIPE_LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(mode), .i_start(start), .i_stall(stall),
    .o_rd_en(rd_en), .o_a_addr(a_addr), .o_b_addr(b_addr),
    .o_acc_we(acc_we), .o_acc_addr(acc_addr), .o_acc_clr(acc_clr), .o_acc_last(acc_last),
    .o_busy(busy), .o_done(done)
`ifdef MM_TILE_SCHED_PERF_EN
    , .o_cycle_cnt(cycle_cnt), .o_stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    string      name;
    logic [1:0] mode;
    int         stall_at;
    int         stall_len;
    int         start_at;
    int         rst_at;
    bit         rnd;
    int         exp_rd;
    int         exp_done;
    int         exp_last_a;
    int         exp_last_b;
    int         exp_cyc;
    int         exp_stl;
  } vec_t;

  typedef struct { int a; int b; int n; int k; } rd_t;
  typedef struct { int cyc; int slot; bit clr; bit last; } acc_t;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint all_outs();
    return longint'({rd_en, a_addr, b_addr, acc_we, acc_addr, acc_clr, acc_last, busy, done});
  endfunction

  task automatic run_vec(input vec_t v);
    rd_t  rdq[$];
    acc_t accq[$];
    rd_t  r;
    int   ks, c, done_cyc, n_rd, n_acc, n_clr, n_done;
    int   e_rd, e_acc, e_busy, e_done, run_stalls, last_a, last_b, quiet;
    bit   stl, exp_rd, exp_we, aborted;

    ks = (v.mode == 2'd1 || v.mode == 2'd2) ? 8 : 16;
    for (int m = 0; m < M_TILES; m++)
      for (int n = 0; n < N_TILES; n++)
        for (int k = 0; k < ks; k++)
          rdq.push_back('{m * 16 + k, n * 16 + k, n, k});
    done_cyc = -1; n_rd = 0; n_acc = 0; n_clr = 0; n_done = 0;
    e_rd = 0; e_acc = 0; e_busy = 0; e_done = 0; run_stalls = 0;
    last_a = -1; last_b = -1; aborted = 0; c = 0;

    @(negedge clk);
    mode  = v.mode;
    start = 1'b1;
    while (c < 6000) begin
      @(posedge clk);
      #1;
      c++;
      start = (c == v.start_at);
      mode  = (c == v.start_at) ? 2'd1 : v.mode;
      stl   = (c >= v.stall_at && c < v.stall_at + v.stall_len) || (v.rnd && $urandom_range(0, 7) == 0);
      stall = stl;
      if (v.rst_at > 0 && c == v.rst_at) begin
        rst_n = 1'b0;
        #1;
        check({v.name, "_rst_outs_zero"}, all_outs(), 0);
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      exp_rd = (rdq.size() > 0) && !stl;
      if (stl && rdq.size() > 0) run_stalls++;
      if (rd_en !== exp_rd) e_rd++;
      else if (exp_rd) begin
        if (a_addr !== 7'(rdq[0].a) || b_addr !== 11'(rdq[0].b)) e_rd++;
      end else if (a_addr !== 7'd0 || b_addr !== 11'd0) e_rd++;
      exp_we = (accq.size() > 0) && (accq[0].cyc == c);
      if (acc_we !== exp_we) e_acc++;
      else if (exp_we) begin
        if (acc_addr !== 4'(accq[0].slot) || acc_clr !== accq[0].clr || acc_last !== accq[0].last) e_acc++;
      end else if (acc_addr !== 4'd0 || acc_clr || acc_last) e_acc++;
      if (exp_we) void'(accq.pop_front());
      if (acc_we) n_acc++;
      if (acc_we && acc_clr) n_clr++;
      if (exp_rd) begin
        r = rdq.pop_front();
        accq.push_back('{c + PIPE_LAT, r.n % 16, r.k == 0, r.k == ks - 1});
        last_a = r.a; last_b = r.b; n_rd++;
        if (rdq.size() == 0) done_cyc = c + PIPE_LAT + 1;
      end
      if (busy !== ((done_cyc < 0) || (c < done_cyc))) e_busy++;
      if (done) begin
        n_done++;
        if (c != done_cyc) e_done++;
      end
      if (done_cyc > 0 && c == done_cyc + 2) break;
    end
    start = 1'b0;
    stall = 1'b0;
    mode  = v.mode;

    check({v.name, "_rd_seq_errs"}, e_rd, 0);
    check({v.name, "_acc_seq_errs"}, e_acc, 0);
    check({v.name, "_busy_errs"}, e_busy, 0);
    if (aborted) begin
      quiet = 0;
      repeat (2) begin
        @(negedge clk);
        if (all_outs() != 0) quiet++;
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) begin
        @(negedge clk);
        if (done || acc_we || busy || rd_en) quiet++;
      end
      check({v.name, "_quiet_after_abort"}, quiet, 0);
      return;
    end
    check({v.name, "_completed"}, longint'(done_cyc > 0), 1);
    check({v.name, "_done_pulses"}, n_done, 1);
    check({v.name, "_done_timing_errs"}, e_done, 0);
    check({v.name, "_rd_count"}, n_rd, (v.exp_rd >= 0) ? v.exp_rd : M_TILES * N_TILES * ks);
    check({v.name, "_acc_count"}, n_acc, n_rd);
    check({v.name, "_clr_count"}, n_clr, M_TILES * N_TILES);
    if (v.exp_done >= 0) check({v.name, "_done_cycle"}, done_cyc, v.exp_done);
    if (v.exp_last_a >= 0) begin
      check({v.name, "_last_a"}, last_a, v.exp_last_a);
      check({v.name, "_last_b"}, last_b, v.exp_last_b);
    end
`ifdef MM_TILE_SCHED_PERF_EN
    check({v.name, "_cycle_cnt"}, cycle_cnt, done_cyc - 1);
    check({v.name, "_stall_cnt"}, stall_cnt, run_stalls);
    if (v.exp_cyc >= 0) begin
      check({v.name, "_cycle_cnt_const"}, cycle_cnt, v.exp_cyc);
      check({v.name, "_stall_cnt_const"}, stall_cnt, v.exp_stl);
    end
`endif
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"int8",          2'd0,   0, 0,   0,   0, 1'b0, 2048, 2052, 127, 255,   -1, -1};
    vecs[1] = '{"int4vsq",       2'd2,   0, 0,   0,   0, 1'b0, 1024, 1028, 119, 247,   -1, -1};
    vecs[2] = '{"stall5",        2'd0, 500, 5,   0,   0, 1'b0, 2048, 2057, 127, 255,   -1, -1};
    vecs[3] = '{"start_ignored", 2'd0,   0, 0, 300,   0, 1'b0, 2048, 2052, 127, 255,   -1, -1};
    vecs[4] = '{"int4_stall7",   2'd1, 200, 7,   0,   0, 1'b0, 1024, 1035, 119, 247, 1034,  7};
    vecs[5] = '{"rst_abort",     2'd0,   0, 0,   0, 100, 1'b0,   -1,   -1,  -1,  -1,   -1, -1};
    vecs[6] = '{"after_rst",     2'd0,   0, 0,   0,   0, 1'b0, 2048, 2052, 127, 255,   -1, -1};
    vecs[7] = '{"rnd_int8",      2'd0,   0, 0,   0,   0, 1'b1,   -1,   -1, 127, 255,   -1, -1};
    vecs[8] = '{"rnd_vsq",       2'd2,   0, 0,   0,   0, 1'b1,   -1,   -1, 119, 247,   -1, -1};
    vecs[9] = '{"reserved_mode", 2'd3,   0, 0,   0,   0, 1'b0, 2048, 2052, 127, 255,   -1, -1};

    repeat (2) @(negedge clk);
    check("reset_outs_zero", all_outs(), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_outs_zero", all_outs(), 0);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
      repeat (2) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
